// File: rtl/out_collector.sv
// out_collector
//   Drains the PE array's shadow accumulator bank after each tile and writes it
//   to output memory. The bank is read one row at a time. Each row is packed
//   into DATA_WIDTH words and written at the tile's place in the
//   BIG_MAC_SIZE x BIG_MAC_SIZE result matrix. Tiles are visited in row-major
//   order (tile_row, tile_col), the same order the input controller uses.
//   done_out pulses once after the last tile of the matrix.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   copy_enb       one-cycle pulse: the shadow bank holds a complete tile
//   res_row_sel    row index into the shadow bank
//   res_row_data   selected row, valid one cycle after res_row_sel changes,
//                  element 0 in the MSBs
//   mem_wr_enb     write request (held until accepted)
//   mem_wr_ready   memory accepts the write this cycle
//   mem_wr_addr    write address
//   mem_wr_data    write data, lowest-indexed element in the MSBs
//   busy           high whenever the collector is not idle
//   done_out       one-cycle pulse after the final write of the final tile
//   overflow_err   sticky: copy_enb arrived while busy
module out_collector #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 23,
    parameter int ACC_WIDTH     = 16,
    parameter int MAC_SIZE      = 32,
    parameter int BIG_MAC_SIZE  = 512,
    parameter int OUT_ADDR_BASE = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            copy_enb,
    output logic [$clog2(MAC_SIZE)-1:0]     res_row_sel,
    input  logic [MAC_SIZE*ACC_WIDTH-1:0]   res_row_data,
    output logic                            mem_wr_enb,
    input  logic                            mem_wr_ready,
    output logic [ADDR_WIDTH-1:0]           mem_wr_addr,
    output logic [DATA_WIDTH-1:0]           mem_wr_data,
    output logic                            busy,
    output logic                            done_out,
    output logic                            overflow_err
);

    localparam int EPW        = DATA_WIDTH / ACC_WIDTH;
    localparam int TILE_WORDS = MAC_SIZE / EPW;
    localparam int ROW_WORDS  = BIG_MAC_SIZE / EPW;
    localparam int DIVIDE     = BIG_MAC_SIZE / MAC_SIZE;
    localparam int ROW_BITS   = MAC_SIZE * ACC_WIDTH;
    localparam int R_BITS     = $clog2(MAC_SIZE);
    localparam int W_BITS     = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) : 1;
    localparam int T_BITS     = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

    localparam logic [R_BITS-1:0] R_LAST = R_BITS'(MAC_SIZE - 1);
    localparam logic [W_BITS-1:0] W_LAST = W_BITS'(TILE_WORDS - 1);
    localparam logic [T_BITS-1:0] T_LAST = T_BITS'(DIVIDE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [R_BITS-1:0]   r;
    logic [W_BITS-1:0]   w;
    logic [T_BITS-1:0]   tile_row;
    logic [T_BITS-1:0]   tile_col;
    logic [ROW_BITS-1:0] row_buf;
    logic [ADDR_WIDTH-1:0] row_base;
    logic                xfer;
    logic                last_tile;

    // Word idx of a row: elements idx*EPW .. idx*EPW+EPW-1. Element 0 sits in
    // the row's MSBs, so word 0 is the top DATA_WIDTH bits.
    function automatic logic [DATA_WIDTH-1:0] word_sel(
        input logic [ROW_BITS-1:0] row,
        input logic [W_BITS-1:0]   idx
    );
        logic [DATA_WIDTH-1:0] word;
        word = '0;
        for (int unsigned k = 0; k < TILE_WORDS; k++) begin
            if (idx == W_BITS'(k)) begin
                word = row[(TILE_WORDS - 1 - k) * DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return word;
    endfunction

    // Address of word 0 of the current row. The arithmetic is done modulo
    // 2^ADDR_WIDTH throughout, which equals truncating the full-width result.
    assign row_base = ADDR_WIDTH'(OUT_ADDR_BASE)
                    + (ADDR_WIDTH'(tile_row) * ADDR_WIDTH'(MAC_SIZE) + ADDR_WIDTH'(r))
                      * ADDR_WIDTH'(ROW_WORDS)
                    + ADDR_WIDTH'(tile_col) * ADDR_WIDTH'(TILE_WORDS);

    assign xfer        = mem_wr_enb & mem_wr_ready;
    assign last_tile   = (tile_row == T_LAST) && (tile_col == T_LAST);
    assign res_row_sel = r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done_out   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (copy_enb) begin
                    state_next = FETCH;
                end
            end
            FETCH: state_next = LOAD;
            LOAD:  state_next = WRITE;
            WRITE: begin
                if (xfer && (w == W_LAST)) begin
                    if (r != R_LAST) begin
                        state_next = FETCH;
                    end else if (last_tile) begin
                        state_next = DONE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r            <= '0;
            w            <= '0;
            tile_row     <= '0;
            tile_col     <= '0;
            row_buf      <= '0;
            mem_wr_enb   <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            overflow_err <= 1'b0;
        end else begin
            // DONE is a busy state, so a pulse there is also an overflow.
            if (copy_enb && (state != IDLE)) begin
                overflow_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (copy_enb) begin
                        r <= '0;
                    end
                end
                LOAD: begin
                    // The first word is taken straight from the bank row so the
                    // registered outputs are ready on the first WRITE cycle.
                    row_buf     <= res_row_data;
                    w           <= '0;
                    mem_wr_enb  <= 1'b1;
                    mem_wr_data <= word_sel(res_row_data, '0);
                    mem_wr_addr <= row_base;
                end
                WRITE: begin
                    if (xfer) begin
                        if (w != W_LAST) begin
                            w           <= w + 1'b1;
                            mem_wr_data <= word_sel(row_buf, w + 1'b1);
                            mem_wr_addr <= mem_wr_addr + 1'b1;
                        end else begin
                            mem_wr_enb <= 1'b0;
                            if (r != R_LAST) begin
                                r <= r + 1'b1;
                            end else if (tile_col == T_LAST) begin
                                tile_col <= '0;
                                tile_row <= tile_row + 1'b1;
                            end else begin
                                tile_col <= tile_col + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    tile_row <= '0;
                    tile_col <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_out_collector.sv
`timescale 1ns/1ps
module tb_out_collector;

    localparam int DW   = 64;
    localparam int AW   = 23;
    localparam int ACC  = 16;
    localparam int MAC  = 8;
    localparam int BIG  = 32;
    localparam int BASE = 0;
    localparam int EPW  = DW / ACC;     // 4
    localparam int TW   = MAC / EPW;    // 2 words per row
    localparam int RW   = BIG / EPW;    // 8 words per matrix row
    localparam int DIV  = BIG / MAC;    // 4 x 4 tiles
    localparam int SELW = $clog2(MAC);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               copy_enb;
    logic [SELW-1:0]    res_row_sel;
    logic [MAC*ACC-1:0] res_row_data;
    logic               mem_wr_enb;
    logic               mem_wr_ready;
    logic [AW-1:0]      mem_wr_addr;
    logic [DW-1:0]      mem_wr_data;
    logic               busy;
    logic               done_out;
    logic               overflow_err;

    out_collector #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .ACC_WIDTH    (ACC),
        .MAC_SIZE     (MAC),
        .BIG_MAC_SIZE (BIG),
        .OUT_ADDR_BASE(BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .copy_enb     (copy_enb),
        .res_row_sel  (res_row_sel),
        .res_row_data (res_row_data),
        .mem_wr_enb   (mem_wr_enb),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .busy         (busy),
        .done_out     (done_out),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Shadow bank with one cycle of read latency.
    logic [ACC-1:0] bank [MAC][MAC];

    function automatic logic [MAC*ACC-1:0] pack_row(input int sel);
        logic [MAC*ACC-1:0] row;
        row = '0;
        for (int c = 0; c < MAC; c++) row = (row << ACC) | (MAC*ACC)'(bank[sel][c]);
        return row;
    endfunction

    always @(posedge clk) res_row_data <= pack_row(int'(res_row_sel));

    // Reference model: list of expected writes for each accepted tile.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  model_tile = 0;

    task automatic model_push();
        int  tr;
        int  tc;
        wr_t e;
        tr = model_tile / DIV;
        tc = model_tile % DIV;
        for (int r = 0; r < MAC; r++) begin
            for (int w = 0; w < TW; w++) begin
                e.addr = AW'(BASE + (tr * MAC + r) * RW + tc * TW + w);
                e.data = '0;
                for (int i = 0; i < EPW; i++) e.data = (e.data << ACC) | DW'(bank[r][w * EPW + i]);
                exp_q.push_back(e);
            end
        end
        model_tile = (model_tile + 1) % (DIV * DIV);
    endtask

    task automatic load_bank(input bit pattern);
        for (int r = 0; r < MAC; r++) begin
            for (int c = 0; c < MAC; c++) begin
                if (pattern) bank[r][c] = ACC'((r << 8) | c);
                else         bank[r][c] = ACC'($urandom);
            end
        end
    endtask

    // Cycle counter and write monitor (sampled on the falling edge).
    int            cyc = 0;
    int            last_xfer_cyc = -100;
    int            tile_writes;
    int            done_cnt;
    logic [AW-1:0] first_addr, last_addr, held_addr;
    logic [DW-1:0] first_data, last_data, held_data;
    bit            stalled = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (stalled) begin
                check("stall_enb", 64'(mem_wr_enb), 64'd1);
                check("stall_addr", 64'(mem_wr_addr), 64'(held_addr));
                check("stall_data", mem_wr_data, held_data);
            end
            stalled   = mem_wr_enb && !mem_wr_ready;
            held_addr = mem_wr_addr;
            held_data = mem_wr_data;
            if (mem_wr_enb && mem_wr_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(mem_wr_addr), 64'(e.addr));
                    check("wr_data", mem_wr_data, e.data);
                end
                if (tile_writes == 0) begin
                    first_addr = mem_wr_addr;
                    first_data = mem_wr_data;
                end
                last_addr     = mem_wr_addr;
                last_data     = mem_wr_data;
                tile_writes++;
                last_xfer_cyc = cyc;
            end
            if (done_out) begin
                done_cnt++;
                check("done_after_last_write", 64'(cyc - last_xfer_cyc), 64'd1);
            end
        end else begin
            stalled = 0;
        end
    end

    // Ready modes: 0 always, 1 pattern 1,0,0,1, 2 random, 3 never.
    int ready_mode = 0;
    int phase = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: mem_wr_ready = 1'b1;
            1: begin
                mem_wr_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
                phase++;
            end
            2: mem_wr_ready = ($urandom_range(0, 3) != 0);
            default: mem_wr_ready = 1'b0;
        endcase
    endtask

    typedef struct {
        int ready_mode;
        int ovf_at;
        bit pattern;
        int exp_first;
        int exp_last;
        int exp_writes;
        int exp_busy;
        bit exp_done;
        bit exp_ovf;
    } vec_t;

    vec_t vt[17];

    task automatic run_tile(input vec_t v, input string tag);
        int k;
        int busy_cnt;
        int first_en;
        k = 0;
        while (busy && k < 1000) begin
            tick();
            k++;
        end
        check({tag, "_idle_before"}, 64'(busy), 64'd0);
        load_bank(v.pattern);
        model_push();
        tile_writes = 0;
        done_cnt    = 0;
        busy_cnt    = 0;
        first_en    = -1;
        ready_mode  = v.ready_mode;
        phase       = 0;
        copy_enb    = 1'b1;
        tick();
        copy_enb    = 1'b0;
        for (k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
            if (mem_wr_enb && first_en < 0) first_en = k;
            copy_enb = (k == v.ovf_at);
            tick();
        end
        copy_enb = 1'b0;
        if (k > 2000) check({tag, "_timeout"}, 64'd1, 64'd0);
        check({tag, "_first_enb_latency"}, 64'(first_en), 64'd3);
        check({tag, "_writes"}, 64'(tile_writes), 64'(v.exp_writes));
        check({tag, "_first_addr"}, 64'(first_addr), 64'(v.exp_first));
        check({tag, "_last_addr"}, 64'(last_addr), 64'(v.exp_last));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(v.exp_done));
        check({tag, "_overflow"}, 64'(overflow_err), 64'(v.exp_ovf));
        check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        if (v.exp_busy >= 0) check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(v.exp_busy));
        repeat (3) tick();
        check({tag, "_no_extra_tile"}, 64'(busy), 64'd0);
    endtask

    function automatic vec_t mk(input int rm, input int ovf, input bit pat, input int f,
                                input int l, input int bc, input bit d, input bit o);
        vec_t v;
        v.ready_mode = rm;
        v.ovf_at     = ovf;
        v.pattern    = pat;
        v.exp_first  = f;
        v.exp_last   = l;
        v.exp_writes = MAC * TW;
        v.exp_busy   = bc;
        v.exp_done   = d;
        v.exp_ovf    = o;
        return v;
    endfunction

    initial begin
        // Tile (tr,tc): first address 64*tr + 2*tc, last = first + 57.
        vt[0]  = mk(0, -1, 1,   0,  57,  32, 0, 0);
        vt[1]  = mk(1, -1, 0,   2,  59,  -1, 0, 0);
        vt[2]  = mk(0, 10, 0,   4,  61,  32, 0, 1);
        vt[3]  = mk(2, -1, 0,   6,  63,  -1, 0, 1);
        vt[4]  = mk(2, -1, 0,  64, 121,  -1, 0, 1);
        vt[5]  = mk(2, -1, 0,  66, 123,  -1, 0, 1);
        vt[6]  = mk(2, -1, 0,  68, 125,  -1, 0, 1);
        vt[7]  = mk(2, -1, 0,  70, 127,  -1, 0, 1);
        vt[8]  = mk(2, -1, 0, 128, 185,  -1, 0, 1);
        vt[9]  = mk(2, -1, 0, 130, 187,  -1, 0, 1);
        vt[10] = mk(2, -1, 0, 132, 189,  -1, 0, 1);
        vt[11] = mk(2, -1, 0, 134, 191,  -1, 0, 1);
        vt[12] = mk(2, -1, 0, 192, 249,  -1, 0, 1);
        vt[13] = mk(2, -1, 0, 194, 251,  -1, 0, 1);
        vt[14] = mk(2, -1, 0, 196, 253,  -1, 0, 1);
        vt[15] = mk(0, -1, 0, 198, 255,  33, 1, 1);
        vt[16] = mk(1, -1, 0,   0,  57,  -1, 0, 1);

        rst_n        = 1'b0;
        copy_enb     = 1'b0;
        mem_wr_ready = 1'b1;
        load_bank(1);
        repeat (3) tick();
        @(negedge clk);
        check("rst_enb", 64'(mem_wr_enb), 64'd0);
        check("rst_addr", 64'(mem_wr_addr), 64'd0);
        check("rst_data", mem_wr_data, 64'd0);
        check("rst_sel", 64'(res_row_sel), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done_out), 64'd0);
        check("rst_ovf", 64'(overflow_err), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            run_tile(vt[i], $sformatf("tile%0d", i));
            if (i == 0) begin
                check("tile0_word0_row0", first_data, 64'h0000_0001_0002_0003);
                check("tile0_word1_row7", last_data, 64'h0704_0705_0706_0707);
            end
        end

        // Reset in the middle of a tile's WRITE phase.
        load_bank(0);
        model_push();
        tile_writes = 0;
        ready_mode  = 0;
        copy_enb    = 1'b1;
        tick();
        copy_enb    = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (mem_wr_enb && tile_writes >= 3) break;
            tick();
        end
        check("midtile_in_write", 64'(mem_wr_enb), 64'd1);
        tick();
        rst_n        = 1'b0;
        ready_mode   = 3;
        mem_wr_ready = 1'b0;
        tick();
        @(negedge clk);
        check("midrst_enb", 64'(mem_wr_enb), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_addr", 64'(mem_wr_addr), 64'd0);
        check("midrst_data", mem_wr_data, 64'd0);
        check("midrst_sel", 64'(res_row_sel), 64'd0);
        check("midrst_ovf", 64'(overflow_err), 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        model_tile = 0;
        tick();
        run_tile(mk(0, -1, 0, 0, 57, 32, 0, 0), "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
